// File: rtl/nco_tune_ctrl_if.sv
// Tune-command channel between the register/control side (master) and nco_tune_ctrl (slave).
// cmd_sync exists only when NCO_PHASE_SYNC_EN is defined.
interface nco_tune_ctrl_if #(
   parameter int WIDTHA = 64,
   parameter int DWELLW = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [WIDTHA-1:0] cmd_target;
   logic [WIDTHA-1:0] cmd_step;
   logic [DWELLW-1:0] cmd_dwell;
`ifdef NCO_PHASE_SYNC_EN
   logic              cmd_sync;

   modport master (
      output cmd_valid, cmd_target, cmd_step, cmd_dwell, cmd_sync,
      input  cmd_ready
   );
   modport slave (
      input  cmd_valid, cmd_target, cmd_step, cmd_dwell, cmd_sync,
      output cmd_ready
   );
`else
   modport master (
      output cmd_valid, cmd_target, cmd_step, cmd_dwell,
      input  cmd_ready
   );
   modport slave (
      input  cmd_valid, cmd_target, cmd_step, cmd_dwell,
      output cmd_ready
   );
`endif
endinterface

// File: rtl/nco_tune_ctrl.sv
// Rate-limited NCO phase_increment ramp: first step one clock after the command handshake, then every dwell+1 clocks.
// One command at a time (cmd_ready only in IDLE); NCO_PHASE_SYNC_EN adds cmd_sync/nco_sync for a phase-coherent NCO restart.
module nco_tune_ctrl #(
   parameter int                WIDTHA    = 64,
   parameter int                DWELLW    = 16,
   parameter logic [WIDTHA-1:0] RESET_INC = '0
) (
   input  logic              clock,
   input  logic              clock_sreset_n,
   nco_tune_ctrl_if.slave    cmd,
   input  logic              abort,
   output logic [WIDTHA-1:0] phase_increment,
   output logic              busy,
   output logic              done
`ifdef NCO_PHASE_SYNC_EN
   ,
   output logic              nco_sync
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q,     state_d;
   logic [WIDTHA-1:0] inc_q,       inc_d;
   logic [WIDTHA-1:0] target_q,    target_d;
   logic [WIDTHA-1:0] step_q,      step_d;
   logic [DWELLW-1:0] dwell_q,     dwell_d;
   logic [DWELLW-1:0] dwell_cnt_q, dwell_cnt_d;
   logic              up_q,        up_d;
   logic              sync_q,      sync_d;

   logic [WIDTHA-1:0] diff;
   logic              snap;
   logic              cmd_rdy;
   logic              cmd_sync_in;

`ifdef NCO_PHASE_SYNC_EN
   assign cmd_sync_in = cmd.cmd_sync;
`else
   assign cmd_sync_in = 1'b0;
`endif

   // Direction is fixed at capture; since steps never overshoot, the distance stays non-negative in that direction.
   assign diff    = up_q ? (target_q - inc_q) : (inc_q - target_q);
   assign snap    = (step_q == '0) || (diff <= step_q);
   assign cmd_rdy = clock_sreset_n && (state_q == ST_IDLE);

   always_comb begin
      state_d     = state_q;
      inc_d       = inc_q;
      target_d    = target_q;
      step_d      = step_q;
      dwell_d     = dwell_q;
      dwell_cnt_d = dwell_cnt_q;
      up_d        = up_q;
      sync_d      = sync_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd.cmd_valid && cmd_rdy) begin
               target_d    = cmd.cmd_target;
               step_d      = cmd.cmd_step;
               dwell_d     = cmd.cmd_dwell;
               sync_d      = cmd_sync_in;
               dwell_cnt_d = '0;
               up_d        = (cmd.cmd_target > inc_q);
               state_d     = ST_RAMP;
            end
         end

         ST_RAMP: begin
            // Abort beats a coinciding final update: value holds, no done pulse.
            if (abort) begin
               sync_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (dwell_cnt_q == '0) begin
               dwell_cnt_d = dwell_q;
               if (snap) begin
                  inc_d   = target_q;
                  state_d = ST_DONE;
               end else if (up_q) begin
                  inc_d = inc_q + step_q;
               end else begin
                  inc_d = inc_q - step_q;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWELLW'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clock_sreset_n) begin
         state_q     <= ST_IDLE;
         inc_q       <= RESET_INC;
         target_q    <= '0;
         step_q      <= '0;
         dwell_q     <= '0;
         dwell_cnt_q <= '0;
         up_q        <= 1'b0;
         sync_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         inc_q       <= inc_d;
         target_q    <= target_d;
         step_q      <= step_d;
         dwell_q     <= dwell_d;
         dwell_cnt_q <= dwell_cnt_d;
         up_q        <= up_d;
         sync_q      <= sync_d;
      end
   end

   assign cmd.cmd_ready   = cmd_rdy;
   assign phase_increment = inc_q;
   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);

`ifdef NCO_PHASE_SYNC_EN
   assign nco_sync = (state_q == ST_DONE) && sync_q;
`endif

   // While ramping, the value always sits on the start side of the target.
   a_no_overshoot: assert property (@(posedge clock) disable iff (!clock_sreset_n)
      (state_q == ST_RAMP) |-> (up_q ? (inc_q <= target_q) : (inc_q >= target_q)));

   a_done_not_ready: assert property (@(posedge clock) disable iff (!clock_sreset_n)
      done |-> !cmd_rdy);

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Bench for nco_tune_ctrl: directed table, hand sequences for abort/back-pressure/reset, randomized commands vs. a timeline model.
module tb_nco_tune_ctrl;
   localparam int          WA   = 64;
   localparam int          DW   = 16;
   localparam logic [63:0] RINC = 64'h1000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        abort = 1'b0;
   logic [63:0] pi;
   logic        busy;
   logic        done;
`ifdef NCO_PHASE_SYNC_EN
   logic        nco_sync;
`endif

   nco_tune_ctrl_if #(.WIDTHA(WA), .DWELLW(DW)) cif ();

   nco_tune_ctrl #(.WIDTHA(WA), .DWELLW(DW), .RESET_INC(RINC)) dut (
      .clock           (clk),
      .clock_sreset_n  (rst_n),
      .cmd             (cif.slave),
      .abort           (abort),
      .phase_increment (pi),
      .busy            (busy),
      .done            (done)
`ifdef NCO_PHASE_SYNC_EN
      ,
      .nco_sync        (nco_sync)
`endif
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [63:0] cur;
   int          obs_chg;
   logic [63:0] obs_first;

   typedef struct {
      logic [63:0] tgt;
      logic [63:0] stp;
      logic [15:0] dw;
      int          exp_chg;
      logic [63:0] exp_first;
      logic [63:0] exp_final;
   } vec_t;

   vec_t tbl [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [66:0] obs();
      return {pi, busy, done, cif.cmd_ready};
   endfunction

   // Number of updates needed: ceil(|t-c|/s), with a jump or equal target counting as one update.
   function automatic int n_steps(input logic [63:0] c, input logic [63:0] t, input logic [63:0] s);
      logic [63:0] diff, q;
      diff = (t > c) ? t - c : c - t;
      if (s == 0 || diff == 0) return 1;
      q = diff / s;
      if (diff % s != 0) q++;
      return int'(q);
   endfunction

   // Value seen after edge k of a ramp accepted at edge 0; updates land at edges 1, 1+(d+1), 1+2(d+1), ...
   function automatic logic [63:0] val_after(input logic [63:0] c, input logic [63:0] t,
                                             input logic [63:0] s, input logic [15:0] d, input int k);
      int n, m;
      if (k == 0) return c;
      n = n_steps(c, t, s);
      m = (k - 1) / (int'(d) + 1) + 1;
      if (m >= n) return t;
      return (t > c) ? c + 64'(m) * s : c - 64'(m) * s;
   endfunction

   task automatic run_cmd(input logic [63:0] t, input logic [63:0] s, input logic [15:0] d,
                          input int abort_at, input bit abort_idle, input bit sync, input string tag);
      int          n, ef;
      logic [63:0] prev, v;
      n  = n_steps(cur, t, s);
      ef = 1 + (n - 1) * (int'(d) + 1);
      cif.cmd_target = t;
      cif.cmd_step   = s;
      cif.cmd_dwell  = d;
      cif.cmd_valid  = 1'b1;
`ifdef NCO_PHASE_SYNC_EN
      cif.cmd_sync   = sync;
`endif
      check({tag, "_ready"}, 67'(cif.cmd_ready), 67'(1));
      abort = abort_idle;
      tick();
      abort = 1'b0;
      cif.cmd_valid = 1'b0;
      check({tag, "_e0"}, obs(), {cur, 3'b100});
      obs_chg = 0;
      obs_first = '0;
      prev = cur;
      for (int k = 1; k <= ef + 1; k++) begin
         if (k == abort_at) abort = 1'b1;
         if (k == ef + 1) abort = abort_idle;
         tick();
         abort = 1'b0;
         if (pi !== prev) begin
            obs_chg++;
            if (obs_chg == 1) obs_first = pi;
            prev = pi;
         end
         if (k == abort_at) begin
            v = val_after(cur, t, s, d, k - 1);
            check({tag, "_abort"}, obs(), {v, 3'b001});
`ifdef NCO_PHASE_SYNC_EN
            check({tag, "_sync_abort"}, 67'(nco_sync), 67'(0));
`endif
            cur = v;
            return;
         end else if (k < ef) begin
            check({tag, "_ramp"}, obs(), {val_after(cur, t, s, d, k), 3'b100});
         end else if (k == ef) begin
            check({tag, "_done"}, obs(), {t, 3'b110});
         end else begin
            check({tag, "_idle"}, obs(), {t, 3'b001});
         end
`ifdef NCO_PHASE_SYNC_EN
         check({tag, "_sync"}, 67'(nco_sync), 67'((k == ef) && sync));
`endif
      end
      cur = t;
   endtask

   initial begin
      logic [63:0] t, s, delta;
      logic [15:0] d;
      int          mode, n, ef, ab;
      bit          up;

      tbl[0] = '{64'h1400, 64'h100, 16'd0, 4, 64'h1100, 64'h1400};
      tbl[1] = '{64'h1050, 64'h100, 16'd2, 4, 64'h1300, 64'h1050};
      tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'd0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[4] = '{64'h0, 64'h0, 16'd5, 1, 64'h0, 64'h0};
      tbl[5] = '{64'h80, 64'h100, 16'd1, 1, 64'h80, 64'h80};
      tbl[6] = '{64'h0, 64'h30, 16'd0, 3, 64'h50, 64'h0};

      cif.cmd_valid  = 1'b0;
      cif.cmd_target = '0;
      cif.cmd_step   = '0;
      cif.cmd_dwell  = '0;
`ifdef NCO_PHASE_SYNC_EN
      cif.cmd_sync   = 1'b0;
`endif

      // Reset
      tick();
      tick();
      check("reset_hold", obs(), {RINC, 3'b000});
      rst_n = 1'b1;
      tick();
      check("reset_release", obs(), {RINC, 3'b001});
      cur = RINC;

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run_cmd(tbl[i].tgt, tbl[i].stp, tbl[i].dw, 0, 1'b0, 1'b1, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_changes", i), 67'(obs_chg), 67'(tbl[i].exp_chg));
         if (tbl[i].exp_chg > 0)
            check($sformatf("tbl%0d_first", i), 67'(obs_first), 67'(tbl[i].exp_first));
         check($sformatf("tbl%0d_final", i), 67'(pi), 67'(tbl[i].exp_final));
      end

      // Abort after 0x300 is reached (update edges 1,5,9,...; abort at edge 10), with abort also high in IDLE/DONE
      run_cmd(64'h1000, 64'h100, 16'd3, 10, 1'b1, 1'b1, "abort");
      check("abort_hold", 67'(pi), 67'(64'h300));
      run_cmd(64'h500, 64'h100, 16'd0, 0, 1'b1, 1'b0, "post_abort");

      // Back-pressure: command B held valid while A ramps 0x500 -> 0x800
      cif.cmd_target = 64'h800;
      cif.cmd_step   = 64'h100;
      cif.cmd_dwell  = 16'd0;
      cif.cmd_valid  = 1'b1;
      tick();
      check("bp_e0", obs(), {64'h500, 3'b100});
      cif.cmd_target = 64'hA00;
      cif.cmd_dwell  = 16'd1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k < 3)       check("bp_ramp", obs(), {val_after(64'h500, 64'h800, 64'h100, 16'd0, k), 3'b100});
         else if (k == 3) check("bp_done", obs(), {64'h800, 3'b110});
         else             check("bp_idle", obs(), {64'h800, 3'b001});
      end
      cur = 64'h800;
      run_cmd(64'hA00, 64'h100, 16'd1, 0, 1'b0, 1'b1, "bp_b");

      // Reset mid-ramp discards the command
      cif.cmd_target = 64'h2000;
      cif.cmd_step   = 64'h10;
      cif.cmd_dwell  = 16'd0;
      cif.cmd_valid  = 1'b1;
      tick();
      cif.cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      check("mid_ramp", obs(), {64'hA30, 3'b100});
      rst_n = 1'b0;
      tick();
      check("mid_reset", obs(), {RINC, 3'b000});
      rst_n = 1'b1;
      tick();
      check("mid_reset_rel", obs(), {RINC, 3'b001});
      tick();
      check("mid_reset_quiet", obs(), {RINC, 3'b001});
      cur = RINC;

      // Randomized commands
      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 2);
         if (mode == 0) begin
            delta = 64'($urandom_range(0, 4000));
            up = 1'($urandom_range(0, 1));
            if (cur < 64'd5000) up = 1'b1;
            if (cur > ~64'd5000) up = 1'b0;
            t = up ? cur + delta : cur - delta;
            s = ($urandom_range(0, 3) == 0) ? 64'h0 : 64'($urandom_range(50, 600));
         end else if (mode == 1) begin
            t = {$urandom, $urandom};
            s = 64'h0;
         end else begin
            t = {$urandom, $urandom};
            s = {$urandom, $urandom} | (64'h1 << 60);
         end
         d  = 16'($urandom_range(0, 3));
         n  = n_steps(cur, t, s);
         ef = 1 + (n - 1) * (int'(d) + 1);
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, ef) : 0;
         run_cmd(t, s, d, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
